// File: rtl/async_result_sync_rx.sv
// async_result_sync_rx: clocked receiver for a dual-rail 4-phase FP32 result channel.
// It detects completion and null on the rails and passes both through synchronisers.
// It captures the true rails into a small FIFO and drives the channel acknowledge.
// Optional feature: define ASYNC_RX_ERR_CHECK_EN to flag illegal (11) pairs on err_o.
module async_result_sync_rx #(
  parameter int EW          = 7,
  parameter int FW          = 23,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [2*FW-1:0]       dr_frac_i,
  input  logic [2*(EW+1)-1:0]   dr_exp_i,
  output logic                  ack_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [1+EW+1+FW-1:0]  res_o,
  output logic                  err_o
);

  localparam int NP = EW + 1 + FW;
  localparam int RW = 1 + EW + 1 + FW;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_ACK     = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2*NP-1:0]        dr_all;
  logic [NP-1:0]          tok_true;
  logic                   complete_raw;
  logic                   null_raw;

  logic [SYNC_STAGES-1:0] cmp_sync_q, cmp_sync_d;
  logic [SYNC_STAGES-1:0] nul_sync_q, nul_sync_d;
  logic                   cmp_s, nul_s;

  logic [2:0]             state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   push, pop;

  logic [RW-1:0]          mem_q [DEPTH];
  logic [RW-1:0]          mem_d [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;

  assign dr_all = {dr_exp_i, dr_frac_i};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Rail decode: completion, null and the true-rail value of every pair
  always_comb begin
    complete_raw = 1'b1;
    null_raw     = 1'b1;
    tok_true     = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      complete_raw = complete_raw & (|dr_all[2*i +: 2]);
      null_raw     = null_raw & ~(|dr_all[2*i +: 2]);
      tok_true[i]  = dr_all[2*i+1];
    end
  end

  // Synchroniser shift for the completion and null detectors
  always_comb begin
    cmp_sync_d = {cmp_sync_q[SYNC_STAGES-2:0], complete_raw};
    nul_sync_d = {nul_sync_q[SYNC_STAGES-2:0], null_raw};
  end

  assign cmp_s = cmp_sync_q[SYNC_STAGES-1];
  assign nul_s = nul_sync_q[SYNC_STAGES-1];

  // Handshake FSM; ack_d is computed from the current state so ack rises on
  // entry to ACK and falls on the edge that leaves RELEASE
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_INIT: begin
        if (nul_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (cmp_s && (count_q < CW'(DEPTH))) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        push    = 1'b1;
        ack_d   = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        ack_d = 1'b1;
        if (nul_s) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign res_valid_o = (count_q != '0);
  assign pop         = res_valid_o & res_ready_i;
  assign res_o       = mem_q[rd_ptr_q];
  assign ack_i       = ack_q;

  // FIFO next-state: write on capture, read on consumer accept
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {1'b0, tok_true};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State, synchroniser and FIFO registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cmp_sync_q <= '0;
      nul_sync_q <= '0;
      state_q    <= S_INIT;
      ack_q      <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      cmp_sync_q <= cmp_sync_d;
      nul_sync_q <= nul_sync_d;
      state_q    <= state_d;
      ack_q      <= ack_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

`ifdef ASYNC_RX_ERR_CHECK_EN
  logic illegal;
  logic err_q, err_d;

  // Any pair carrying 11 is an illegal codeword
  always_comb begin
    illegal = 1'b0;
    for (int unsigned i = 0; i < NP; i++) begin
      illegal = illegal | (&dr_all[2*i +: 2]);
    end
  end

  // Sticky error, sampled only while capturing
  always_comb begin
    err_d = err_q | (push & illegal);
  end

  // Error flag register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_async_result_sync_rx.sv
// Scoreboard bench for async_result_sync_rx: expected results are queued when a
// token is sent and a monitor compares each FIFO transfer against the queue head.
module tb_async_result_sync_rx;
  localparam int EW = 7;
  localparam int FW = 23;

  logic                 clk = 1'b0;
  logic                 arst_n;
  logic [2*FW-1:0]      dr_frac;
  logic [2*(EW+1)-1:0]  dr_exp;
  logic                 ack;
  logic                 res_valid;
  logic                 res_ready;
  logic [31:0]          res;
  logic                 err;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];

`ifdef ASYNC_RX_ERR_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  async_result_sync_rx #(.EW(EW), .FW(FW), .SYNC_STAGES(2), .DEPTH(2)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .dr_frac_i   (dr_frac),
    .dr_exp_i    (dr_exp),
    .ack_i       (ack),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_o       (res),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_token(input logic [7:0] e, input logic [22:0] f);
    for (int i = 0; i < FW; i++) dr_frac[2*i +: 2] = f[i] ? 2'b10 : 2'b01;
    for (int i = 0; i < EW+1; i++) dr_exp[2*i +: 2] = e[i] ? 2'b10 : 2'b01;
  endtask

  task automatic set_null();
    dr_frac = '0;
    dr_exp  = '0;
  endtask

  task automatic wait_ack(input logic lvl, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (ack !== lvl && n < 30);
  endtask

  task automatic send(input logic [7:0] e, input logic [22:0] f, input logic bad,
                      input logic [31:0] expv, output int nup, output int ndn);
    exp_q.push_back(expv);
    set_token(e, f);
    if (bad) dr_frac[1:0] = 2'b11;
    wait_ack(1'b1, nup);
    set_null();
    wait_ack(1'b0, ndn);
  endtask

  task automatic drain(input string name);
    int k = 0;
    res_ready = 1'b1;
    while (exp_q.size() != 0 && k < 30) begin
      cycle();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every accepted head is compared with the oldest expected result
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL pop_unexpected: got %h want no transfer", res);
        end else begin
          e = exp_q.pop_front();
          if (res !== e) begin
            n_bad++;
            $display("FAIL pop_data: got %h want %h", res, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nup, ndn;
    arst_n    = 1'b0;
    res_ready = 1'b0;
    set_token(8'hFF, 23'h7FFFFF);
    cycle();
    cycle();
    check("rst_ack", ack, 0);
    check("rst_valid", res_valid, 0);
    check("rst_res", res, 32'h0);
    check("rst_err", err, 0);

    // stale token at reset release must not be captured
    arst_n = 1'b1;
    repeat (10) cycle();
    check("t1_stale_ack", ack, 0);
    check("t1_stale_valid", res_valid, 0);
    set_null();
    repeat (10) cycle();
    check("t1_null_ack", ack, 0);
    check("t1_null_valid", res_valid, 0);

    // single token, latency in both phases
    res_ready = 1'b1;
    exp_q.push_back(32'h3FC00000);
    set_token(8'h7F, 23'h400000);
    wait_ack(1'b1, nup);
    check("t2_ack_rise_lat", nup, 4);
    check("t2_valid_with_ack", res_valid, 1);
    check("t2_res", res, 32'h3FC00000);
    set_null();
    wait_ack(1'b0, ndn);
    check("t2_ack_fall_lat", ndn, 4);
    check("t2_valid_after_pop", res_valid, 0);

    // backpressure with DEPTH=2
    res_ready = 1'b0;
    send(8'h80, 23'h000000, 1'b0, 32'h40000000, nup, ndn);
    check("t3_a_lat", nup, 4);
    send(8'h81, 23'h200000, 1'b0, 32'h40A00000, nup, ndn);
    exp_q.push_back(32'h3F7FFFFF);
    set_token(8'h7E, 23'h7FFFFF);
    repeat (10) cycle();
    check("t3_held_ack", ack, 0);
    check("t3_full_valid", res_valid, 1);
    check("t3_head_stable", res, 32'h40000000);
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    wait_ack(1'b1, nup);
    check("t3_third_lat", nup, 2);
    set_null();
    wait_ack(1'b0, ndn);
    drain("t3_drain");

    // push and pop on the same edge with one entry queued
    res_ready = 1'b0;
    send(8'h01, 23'h000001, 1'b0, 32'h00800001, nup, ndn);
    cycle();
    cycle();
    exp_q.push_back(32'h7F7FFFFF);
    set_token(8'hFE, 23'h7FFFFF);
    cycle();
    cycle();
    cycle();
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    check("t4_ack", ack, 1);
    check("t4_valid", res_valid, 1);
    check("t4_head_adv", res, 32'h7F7FFFFF);
    set_null();
    wait_ack(1'b0, ndn);
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    check("t4_count_one", res_valid, 0);

    // reset while in ACK
    exp_q.push_back(32'h2AAAAAAA);
    set_token(8'h55, 23'h2AAAAA);
    wait_ack(1'b1, nup);
    check("t5_ack_up", ack, 1);
    #2;
    arst_n = 1'b0;
    #1;
    check("t5_ack_drop", ack, 0);
    check("t5_valid_drop", res_valid, 0);
    check("t5_res_clear", res, 32'h0);
    exp_q.delete();
    cycle();
    arst_n = 1'b1;
    repeat (10) cycle();
    check("t5_init_ack", ack, 0);
    check("t5_init_valid", res_valid, 0);
    set_null();
    repeat (5) cycle();
    send(8'h80, 23'h490FDB, 1'b0, 32'h40490FDB, nup, ndn);
    check("t5_resume_lat", nup, 4);
    drain("t5_drain");

    // illegal pair: captured by true rail, error flag sticky when enabled
    res_ready = 1'b1;
    send(8'h00, 23'h000000, 1'b1, 32'h00000001, nup, ndn);
    check("t6_err_set", err, ERR_EXP);
    send(8'h7F, 23'h000000, 1'b0, 32'h3F800000, nup, ndn);
    check("t6_err_sticky", err, ERR_EXP);
    drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
